// File: rtl/md_ctrl_if.sv
// Signal bundle between md_ctrl, the EX stage, the multiply/divide units and HI/LO.
// master: controller side; slave: pipeline/unit side.
interface md_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 op_valid_i;
  logic [3:0]           op_i;
  logic [WIDTH-1:0]     op1_i;
  logic [WIDTH-1:0]     op2_i;
  logic [WIDTH-1:0]     hi_i;
  logic [WIDTH-1:0]     lo_i;
  logic                 flush_i;
  logic                 mul_start_o;
  logic                 div_start_o;
  logic                 mul_signed_o;
  logic                 div_signed_o;
  logic [WIDTH-1:0]     md_op1_o;
  logic [WIDTH-1:0]     md_op2_o;
  logic                 md_annul_o;
  logic [2*WIDTH-1:0]   mul_result_i;
  logic [2*WIDTH-1:0]   div_result_i;
  logic                 mul_ready_i;
  logic                 div_ready_i;
  logic                 stallreq_o;
  logic                 hilo_we_o;
  logic [WIDTH-1:0]     hi_o;
  logic [WIDTH-1:0]     lo_o;
  logic                 timeout_o;

  modport master (
    input  op_valid_i, op_i, op1_i, op2_i, hi_i, lo_i, flush_i,
    input  mul_result_i, div_result_i, mul_ready_i, div_ready_i,
    output mul_start_o, div_start_o, mul_signed_o, div_signed_o,
    output md_op1_o, md_op2_o, md_annul_o,
    output stallreq_o, hilo_we_o, hi_o, lo_o, timeout_o
  );

  modport slave (
    output op_valid_i, op_i, op1_i, op2_i, hi_i, lo_i, flush_i,
    output mul_result_i, div_result_i, mul_ready_i, div_ready_i,
    input  mul_start_o, div_start_o, mul_signed_o, div_signed_o,
    input  md_op1_o, md_op2_o, md_annul_o,
    input  stallreq_o, hilo_we_o, hi_o, lo_o, timeout_o
  );
endinterface

// File: rtl/md_ctrl.sv
// EX-stage sequencer for the multi-cycle multiply/divide units with a single HI/LO write.
// Define MD_ACC_EN to accept MADD/MADDU/MSUB/MSUBU (HI/LO accumulate through an ACC state).
module md_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rst,
  md_ctrl_if.master bus
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_WAIT,
    S_DIV_WAIT,
    S_DONE
`ifdef MD_ACC_EN
    , S_ACC
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_start_q, mul_start_d;
  logic             div_start_q, div_start_d;
  logic             mul_signed_q, mul_signed_d;
  logic             div_signed_q, div_signed_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             timeout_q, timeout_d;

  logic             stall_c, we_c, annul_c;
  logic             op_known, op_mul, op_signed, accept;

`ifdef MD_ACC_EN
  logic             op_acc, op_sub;
  logic             acc_q, acc_d;
  logic             sub_q, sub_d;
  logic [DW-1:0]    prod_q, prod_d;
  logic [DW-1:0]    acc_sum;
`else
  logic             unused_hilo;
  assign unused_hilo = ^{bus.hi_i, bus.lo_i};
`endif

  // Opcode decode; unsupported codes leave op_known low and are ignored.
  always_comb begin
    op_known  = 1'b0;
    op_mul    = 1'b0;
    op_signed = 1'b0;
`ifdef MD_ACC_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    case (bus.op_i)
      4'd1: begin op_known = 1'b1; op_mul = 1'b1; op_signed = 1'b1; end
      4'd2: begin op_known = 1'b1; op_mul = 1'b1; end
      4'd3: begin op_known = 1'b1; op_signed = 1'b1; end
      4'd4: begin op_known = 1'b1; end
`ifdef MD_ACC_EN
      4'd5: begin op_known = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      4'd6: begin op_known = 1'b1; op_mul = 1'b1; op_acc = 1'b1; end
      4'd7: begin op_known = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd8: begin op_known = 1'b1; op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept = bus.op_valid_i && op_known && !bus.flush_i;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_start_d  = mul_start_q;
    div_start_d  = div_start_q;
    mul_signed_d = mul_signed_q;
    div_signed_d = div_signed_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    timeout_d    = 1'b0;
    stall_c      = 1'b0;
    we_c         = 1'b0;
    annul_c      = 1'b0;
`ifdef MD_ACC_EN
    acc_d        = acc_q;
    sub_d        = sub_q;
    prod_d       = prod_q;
    acc_sum      = sub_q ? ({bus.hi_i, bus.lo_i} - prod_q) : ({bus.hi_i, bus.lo_i} + prod_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_c = 1'b1;
          op1_d   = bus.op1_i;
          op2_d   = bus.op2_i;
          cnt_d   = '0;
          if (op_mul) begin
            state_d      = S_MUL_WAIT;
            mul_start_d  = 1'b1;
            mul_signed_d = op_signed;
`ifdef MD_ACC_EN
            acc_d        = op_acc;
            sub_d        = op_sub;
`endif
          end else if (bus.op2_i == '0) begin
            // Divide by zero never reaches the unit; HI/LO are written as zero.
            hi_d    = '0;
            lo_d    = '0;
            state_d = S_DONE;
          end else begin
            state_d      = S_DIV_WAIT;
            div_start_d  = 1'b1;
            div_signed_d = op_signed;
          end
        end
      end

      S_MUL_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (bus.flush_i) begin
          annul_c     = 1'b1;
          mul_start_d = 1'b0;
          state_d     = S_IDLE;
        end else if (bus.mul_ready_i) begin
          mul_start_d = 1'b0;
`ifdef MD_ACC_EN
          if (acc_q) begin
            prod_d  = bus.mul_result_i;
            state_d = S_ACC;
          end else begin
            hi_d    = bus.mul_result_i[DW-1:WIDTH];
            lo_d    = bus.mul_result_i[WIDTH-1:0];
            state_d = S_DONE;
          end
`else
          hi_d    = bus.mul_result_i[DW-1:WIDTH];
          lo_d    = bus.mul_result_i[WIDTH-1:0];
          state_d = S_DONE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          annul_c     = 1'b1;
          timeout_d   = 1'b1;
          mul_start_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_DIV_WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (bus.flush_i) begin
          annul_c     = 1'b1;
          div_start_d = 1'b0;
          state_d     = S_IDLE;
        end else if (bus.div_ready_i) begin
          div_start_d = 1'b0;
          hi_d        = bus.div_result_i[DW-1:WIDTH];
          lo_d        = bus.div_result_i[WIDTH-1:0];
          state_d     = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          annul_c     = 1'b1;
          timeout_d   = 1'b1;
          div_start_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

`ifdef MD_ACC_EN
      // Forwarded HI/LO are sampled here, one cycle after the product arrives.
      S_ACC: begin
        stall_c = 1'b1;
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = acc_sum[DW-1:WIDTH];
          lo_d    = acc_sum[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
`endif

      // The EX instruction retires here, so IDLE never sees it again.
      S_DONE: begin
        we_c    = !bus.flush_i;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      div_signed_q <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      timeout_q    <= 1'b0;
`ifdef MD_ACC_EN
      acc_q        <= 1'b0;
      sub_q        <= 1'b0;
      prod_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_start_q  <= mul_start_d;
      div_start_q  <= div_start_d;
      mul_signed_q <= mul_signed_d;
      div_signed_q <= div_signed_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      timeout_q    <= timeout_d;
`ifdef MD_ACC_EN
      acc_q        <= acc_d;
      sub_q        <= sub_d;
      prod_q       <= prod_d;
`endif
    end
  end

  assign bus.mul_start_o  = mul_start_q;
  assign bus.div_start_o  = div_start_q;
  assign bus.mul_signed_o = mul_signed_q;
  assign bus.div_signed_o = div_signed_q;
  assign bus.md_op1_o     = op1_q;
  assign bus.md_op2_o     = op2_q;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.md_annul_o   = annul_c;
  assign bus.stallreq_o   = stall_c;
  assign bus.hilo_we_o    = we_c;

endmodule
